// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: HALT opcode, default
// address width and the fetch FSM state type.
package if_pkg;

  localparam int unsigned PC_W_DEF = 16;

  localparam int unsigned OPC_MSB  = 31;
  localparam int unsigned OPC_LSB  = 25;
  localparam logic [6:0]  OPC_HALT = 7'b1101000;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  function automatic logic is_halt(input logic [31:0] word);
    return (word[OPC_MSB:OPC_LSB] == OPC_HALT);
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {instr, pc} holding register that absorbs the memory response
// arriving while the decoder is stalled.
module if_skid_buf
  import if_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            load,
  input  logic            drain,
  input  logic [31:0]     load_instr,
  input  logic [PC_W-1:0] load_pc,
  output logic            valid,
  output logic [31:0]     instr,
  output logic [PC_W-1:0] pc
);

  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] pc_q, pc_d;

  // Next entry; load wins over drain so a same-cycle drain-and-refill keeps it full.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = load_instr;
      pc_d    = load_pc;
    end else if (drain) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Entry register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= 32'h0000_0000;
      pc_q    <= {PC_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/if_stage_chk.sv
// Invariant checker for if_stage: the out register plus skid must always have
// room for a live memory response.
module if_stage_chk (
  input logic clk,
  input logic rst_n,
  input logic instr_valid,
  input logic skid_valid,
  input logic resp,
  input logic consume
);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(resp && instr_valid && skid_valid && !consume));

  a_skid_behind_out: assert property (@(posedge clk) disable iff (!rst_n)
    skid_valid |-> instr_valid);

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, synchronous imem reads, IF/ID register with skid
// and branch redirect. Define IF_HALT_DETECT_EN to stop fetching after a HALT.
module if_stage
  import if_pkg::*;
#(
  parameter int unsigned      PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0]  RESET_PC = {PC_W{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_rd_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr_out,
  output logic [PC_W-1:0] pc_out,
  output logic            instr_valid,
  input  logic            id_ready,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic            halted
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
  logic            instr_valid_q, instr_valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] pc_out_q, pc_out_d;

  logic            run_s;
  logic            br_s;
  logic            issue_s;
  logic            consume_s;
  logic            resp_s;
  logic            skid_valid_s;
  logic [31:0]     skid_instr_s;
  logic [PC_W-1:0] skid_pc_s;
  logic            skid_load_s;
  logic            skid_drain_s;

`ifdef IF_HALT_DETECT_EN
  fetch_state_t state_q, state_d;

  // HALT is recognised on a captured response and is permanent until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (resp_s && is_halt(imem_rdata)) begin
          state_d = HALTED;
        end else begin
          state_d = RUN;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // Fetch state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign run_s  = (state_q == RUN);
  assign halted = (state_q == HALTED);
`else
  assign run_s  = 1'b1;
  assign halted = 1'b0;
`endif

  assign br_s      = br_taken & run_s;
  assign consume_s = instr_valid_q & id_ready;
  assign resp_s    = inflight_q & run_s & ~br_s;
  assign issue_s   = run_s & ~br_taken & ~skid_valid_s
                   & ~(inflight_q & instr_valid_q & ~id_ready);

  // Reset gating keeps the strobe low while rst_n is held.
  assign imem_rd_en = issue_s & rst_n;
  assign imem_addr  = pc_q;

  // PC and in-flight tracking.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue_s;
    inflight_pc_d = inflight_pc_q;
    if (br_s) begin
      pc_d = br_target;
    end else if (issue_s) begin
      pc_d          = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
      inflight_pc_d = pc_q;
    end else begin
      pc_d = pc_q;
    end
  end

  // Out register / skid steering; the skid drains ahead of a new response.
  always_comb begin
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    pc_out_d      = pc_out_q;
    skid_load_s   = 1'b0;
    skid_drain_s  = 1'b0;
    if (br_s) begin
      instr_valid_d = 1'b0;
    end else begin
      case ({consume_s, skid_valid_s, resp_s})
        3'b110, 3'b111: begin
          instr_valid_d = 1'b1;
          instr_d       = skid_instr_s;
          pc_out_d      = skid_pc_s;
          skid_drain_s  = 1'b1;
          skid_load_s   = resp_s;
        end
        3'b101: begin
          instr_valid_d = 1'b1;
          instr_d       = imem_rdata;
          pc_out_d      = inflight_pc_q;
        end
        3'b100: begin
          instr_valid_d = 1'b0;
        end
        3'b001, 3'b011: begin
          if (instr_valid_q) begin
            skid_load_s = 1'b1;
          end else begin
            instr_valid_d = 1'b1;
            instr_d       = imem_rdata;
            pc_out_d      = inflight_pc_q;
          end
        end
        default: begin
          instr_valid_d = instr_valid_q;
        end
      endcase
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= {PC_W{1'b0}};
      instr_valid_q <= 1'b0;
      instr_q       <= 32'h0000_0000;
      pc_out_q      <= {PC_W{1'b0}};
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      pc_out_q      <= pc_out_d;
    end
  end

  if_skid_buf #(.PC_W(PC_W)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (br_s),
    .load       (skid_load_s),
    .drain      (skid_drain_s),
    .load_instr (imem_rdata),
    .load_pc    (inflight_pc_q),
    .valid      (skid_valid_s),
    .instr      (skid_instr_s),
    .pc         (skid_pc_s)
  );

  if_stage_chk u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid_q),
    .skid_valid  (skid_valid_s),
    .resp        (resp_s),
    .consume     (consume_s)
  );

  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: queue-based reference model checked every cycle, plus
// hand-computed expectations for streaming, stall, branch, wrap, HALT and reset.
module tb_if_stage;

  localparam logic [6:0] HALT_OPC = 7'b1101000;
`ifdef IF_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_rd_en;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr_out;
  logic [15:0] pc_out;
  logic        instr_valid;
  logic        id_ready = 1'b1;
  logic        br_taken = 1'b0;
  logic [15:0] br_target = 16'h0;
  logic        halted;

  logic        rd_en2;
  logic [15:0] addr2;
  logic [31:0] rdata2 = 32'h0;
  logic [31:0] instr2;
  logic [15:0] pc2;
  logic        valid2;
  logic        ready2 = 1'b1;
  logic        br2 = 1'b0;
  logic [15:0] brt2 = 16'h0;
  logic        halted2;

  bit halt_mode = 1'b0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr_out(instr_out), .pc_out(pc_out),
    .instr_valid(instr_valid), .id_ready(id_ready), .br_taken(br_taken),
    .br_target(br_target), .halted(halted)
  );

  if_stage #(.PC_W(16), .RESET_PC(16'hFFFE)) dut2 (
    .clk(clk), .rst_n(rst_n), .imem_rd_en(rd_en2), .imem_addr(addr2),
    .imem_rdata(rdata2), .instr_out(instr2), .pc_out(pc2),
    .instr_valid(valid2), .id_ready(ready2), .br_taken(br2),
    .br_target(brt2), .halted(halted2)
  );

  function automatic logic [31:0] mem_word(input logic [15:0] a, input bit hm);
    if (hm && a == 16'd3) return 32'hD000_0000;
    return 32'h1000_0000 | {16'h0000, a};
  endfunction

  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem_word(imem_addr, halt_mode);
    if (rd_en2) rdata2 <= mem_word(addr2, 1'b0);
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a fetch pointer, one outstanding request and an ordered
  // buffer of up to two delivered-but-unconsumed instructions.
  ent_t        q[$];
  logic [15:0] m_pc;
  bit          m_req;
  logic [15:0] m_req_pc;
  bit          m_halt;
  bit          m_issue;
  bit          m_cons;
  ent_t        m_e;

  initial begin
    m_pc = 16'h0; m_req = 1'b0; m_req_pc = 16'h0; m_halt = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        m_pc = 16'h0; m_req = 1'b0; m_halt = 1'b0;
        chk("reset_outputs",
            {imem_rd_en, imem_addr, instr_out, pc_out, instr_valid, halted},
            {1'b0, 16'h0000, 32'h0, 16'h0000, 1'b0, 1'b0});
      end else begin
        m_issue = !m_halt && !br_taken && (q.size() < 2) &&
                  !(m_req && q.size() >= 1 && !id_ready);
        chk("model_rd_en", imem_rd_en, m_issue);
        if (m_issue) chk("model_rd_addr", imem_addr, m_pc);
        chk("model_valid", instr_valid, q.size() > 0);
        if (q.size() > 0) begin
          chk("model_pc_out", pc_out, q[0].pc);
          chk("model_instr_out", instr_out, q[0].instr);
        end
        chk("model_halted", halted, m_halt);
        m_cons = (q.size() > 0) && id_ready;
        if (br_taken && !m_halt) begin
          q.delete();
          m_pc  = br_target;
          m_req = 1'b0;
        end else begin
          if (m_cons) void'(q.pop_front());
          if (m_req && !m_halt) begin
            m_e.pc    = m_req_pc;
            m_e.instr = mem_word(m_req_pc, halt_mode);
            q.push_back(m_e);
            if (HALT_EN && m_e.instr[31:25] == HALT_OPC) m_halt = 1'b1;
          end
          m_req    = m_issue;
          m_req_pc = m_pc;
          if (m_issue) m_pc = m_pc + 16'd1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int rd_cnt;

  initial begin
    // Segment A: streaming, stall, branch; dut2 checks address wrap.
    repeat (3) tick();
    rst_n = 1'b1;
    #2 chk("A_c0_rd_en", imem_rd_en, 1'b1);
    tick(); #2 chk("A_c1_valid", instr_valid, 1'b0);
    tick();
    #2 chk("A_c2_out", {instr_valid, pc_out, instr_out}, {1'b1, 16'h0000, 32'h1000_0000});
    chk("W_c2", {valid2, pc2, instr2}, {1'b1, 16'hFFFE, 32'h1000_FFFE});
    tick();
    #2 chk("A_c3_pc", pc_out, 16'h0001);
    chk("W_c3", pc2, 16'hFFFF);
    tick();
    #2 chk("A_c4_pc", pc_out, 16'h0002);
    chk("W_c4", {pc2, instr2}, {16'h0000, 32'h1000_0000});
    tick();
    id_ready = 1'b0;
    rd_cnt = 0;
    #2 chk("A_c5_pc", pc_out, 16'h0003);
    rd_cnt += int'(imem_rd_en);
    for (int i = 6; i <= 9; i++) begin
      tick();
      #2 rd_cnt += int'(imem_rd_en);
    end
    chk("A_c9_stalled", {instr_valid, pc_out, instr_out}, {1'b1, 16'h0003, 32'h1000_0003});
    chk("A_stall_reads", rd_cnt, 0);
    tick();
    id_ready = 1'b1;
    #2 chk("A_c10_pc", pc_out, 16'h0003);
    tick(); #2 chk("A_c11_pc", pc_out, 16'h0004);
    tick();
    tick();
    br_taken = 1'b1; br_target = 16'h0040;
    #2 chk("A_c13_pc", pc_out, 16'h0005);
    tick();
    br_taken = 1'b0;
    #2 chk("A_c14_valid", instr_valid, 1'b0);
    tick(); #2 chk("A_c15_valid", instr_valid, 1'b0);
    tick();
    #2 chk("A_c16_target", {instr_valid, pc_out, instr_out}, {1'b1, 16'h0040, 32'h1000_0040});
    tick(); #2 chk("A_c17_pc", pc_out, 16'h0041);
    repeat (4) tick();

    // Segment B: HALT word at address 3.
    rst_n = 1'b0;
    halt_mode = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    #2 chk("B_c5_halt_word", {instr_valid, pc_out, instr_out}, {1'b1, 16'h0003, 32'hD000_0000});
`ifdef IF_HALT_DETECT_EN
    chk("B_c5_halted", {halted, imem_rd_en}, {1'b1, 1'b0});
    tick(); #2 chk("B_c6_valid", instr_valid, 1'b0);
    tick();
    br_taken = 1'b1; br_target = 16'h0100;
    #2 chk("B_c7_br_ignored", imem_rd_en, 1'b0);
    tick();
    br_taken = 1'b0;
    tick(); tick();
    #2 chk("B_c10_idle", {instr_valid, halted, imem_rd_en}, {1'b0, 1'b1, 1'b0});
`else
    chk("B_c5_halted", halted, 1'b0);
    tick(); #2 chk("B_c6_pc", pc_out, 16'h0004);
    tick();
    br_taken = 1'b1; br_target = 16'h0100;
    #2 chk("B_c7_pc", pc_out, 16'h0005);
    tick();
    br_taken = 1'b0;
    tick(); tick();
    #2 chk("B_c10_target", {instr_valid, pc_out}, {1'b1, 16'h0100});
`endif
    repeat (2) tick();

    // Segment C: reset asserted while out and skid are both full.
    rst_n = 1'b0;
    halt_mode = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    id_ready = 1'b0;
    tick();
    #2 chk("C_c6_stalled", {instr_valid, pc_out}, {1'b1, 16'h0003});
    tick();
    rst_n = 1'b0;
    #1 chk("C_async_reset",
           {imem_rd_en, imem_addr, instr_out, pc_out, instr_valid, halted},
           {1'b0, 16'h0000, 32'h0, 16'h0000, 1'b0, 1'b0});
    id_ready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    #2 chk("C_restart_addr", {imem_rd_en, imem_addr}, {1'b1, 16'h0000});
    tick(); tick();
    #2 chk("C_restart_out", {instr_valid, pc_out, instr_out}, {1'b1, 16'h0000, 32'h1000_0000});
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
